// File: rtl/counter_pkg.sv
// Shared encodings for the counter/timer: FSM states plus direction and mode constants.
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DN   = 1'b1;
  localparam logic MODE_PER = 1'b0;
  localparam logic MODE_ONE = 1'b1;

endpackage

// File: rtl/counter_psc.sv
// Prescaler for counter_timer: divides the step rate by psc+1 while the timer runs.
// Only instantiated when COUNTER_TIMER_PRESCALER_EN is defined.
module counter_psc #(
  parameter int PW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          run,
  input  logic          ena,
  input  logic [PW-1:0] psc,
  output logic          tick
);

  logic [PW-1:0] div;

  assign tick = run && ena && (div == psc);

  // Outside RUN the divider sits at zero so each run starts a full period.
  always_ff @(posedge clk) begin
    if (rst || clr || !run) begin
      div <= '0;
    end else if (ena) begin
      div <= (div == psc) ? '0 : div + 1'b1;
    end
  end

endmodule

// File: rtl/counter_timer.sv
// Programmable-period up/down counter/timer with one-shot/periodic mode, load, compare, tc.
// Optional prescaler enabled by defining COUNTER_TIMER_PRESCALER_EN.
module counter_timer
  import counter_pkg::*;
#(
  parameter int CW = 3,
  parameter int PW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic          clr,
  input  logic          ld,
  input  logic [CW-1:0] ld_val,
  input  logic [CW-1:0] prd,
  input  logic [CW-1:0] cmp,
  input  logic          dir,
  input  logic          mode,
`ifdef COUNTER_TIMER_PRESCALER_EN
  input  logic [PW-1:0] psc,
`endif
  output logic [CW-1:0] cnt,
  output logic          out,
  output logic          tc,
  output logic          match
);

  state_t        state, state_nxt;
  logic          tick;
  logic          step;
  logic          wrap;
  logic [CW-1:0] step_val;

`ifdef COUNTER_TIMER_PRESCALER_EN
  counter_psc #(.PW(PW)) u_psc (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .run  (state == RUN),
    .ena  (ena),
    .psc  (psc),
    .tick (tick)
  );
`else
  // Without a prescaler every cycle is a tick; a zero-width divider would mean the same.
  localparam logic TICK_ALWAYS = (PW >= 0);
  assign tick = TICK_ALWAYS;
`endif

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    step     = 1'b0;
    wrap     = 1'b0;
    step_val = cnt;
    step     = (state == RUN) && ena && tick && !clr && !ld;
    if (dir == DIR_UP) begin
      wrap     = (cnt >= prd);
      step_val = wrap ? '0 : cnt + 1'b1;
    end else begin
      wrap     = (cnt == '0);
      step_val = wrap ? prd : cnt - 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (ena) state_nxt = RUN;
        RUN:     if (step && wrap && mode == MODE_ONE) state_nxt = DONE;
        DONE:    state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      out   <= 1'b0;
      tc    <= 1'b0;
      match <= 1'b0;
    end else begin
      state <= state_nxt;
      out   <= ena && (state_nxt == RUN);
      tc    <= 1'b0;
      match <= 1'b0;
      if (clr) begin
        cnt <= '0;
      end else if (ld) begin
        cnt   <= ld_val;
        match <= (ld_val == cmp);
      end else if (step) begin
        cnt   <= step_val;
        tc    <= wrap;
        match <= (step_val == cmp);
      end
    end
  end

endmodule
